mmc_cmd_serializer: RTL
=======================

Name: mmc_cmd_serializer

Overview:
Parametrised MMC/SD command-line transmitter. It accepts any 6-bit command index and 32-bit argument through a valid/ready handshake. It builds the 48-bit frame (start, transmission bit, index, argument, CRC7, stop) and shifts it out MSB-first at a programmable bit rate, computing CRC7 serially instead of using hard-wired per-command tables. It sits between the boot/command state machine and the CMD pad driver, followed by a mandatory inter-command idle gap.

Parameters:
CLK_DIV, 2, clk cycles per CMD bit period; legal range 1..255
GAP_BITS, 8, bit periods of idle (line released, high) after each frame before cmd_ready re-asserts; 0 allowed
CRC_EN, 1, 1 = internal CRC7 generator; 0 = transmit cmd_crc input as supplied

Ports:
clk  in  1  system clock; the block's only clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_index  in  6  command index, captured on handshake
cmd_arg  in  32  command argument, captured on handshake
cmd_crc  in  7  external CRC7, captured on handshake; used only when CRC_EN=0
cmd_out  out  1  serial CMD data to pad
cmd_oe  out  1  pad output enable, high for frame bits 0..47 only
busy  out  1  high in SEND and GAP
bit_cnt  out  6  current frame bit index 0..47; 0 outside SEND
done  out  1  one-cycle pulse at frame completion

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered. Reset values: cmd_out=1, cmd_oe=0, cmd_ready=0, busy=0, bit_cnt=0, done=0, state=IDLE, CRC register=0. cmd_ready rises in the first cycle after rst deasserts.
- States:
  - IDLE: cmd_ready=1.
  - SEND: 48 bit periods.
  - GAP: GAP_BITS bit periods.
- IDLE→SEND on cmd_valid & cmd_ready in cycle T. Inputs are latched in T and later input changes are ignored. cmd_ready=0 from T+1. Bit 0 drives from T+1 with cmd_oe=1.
- Frame bit map:
  - bit 0 = 0 (start)
  - bit 1 = 1 (transmission)
  - bits 2..7 = cmd_index[5:0], MSB first
  - bits 8..39 = cmd_arg[31:0], MSB first
  - bits 40..46 = CRC7[6:0], MSB first
  - bit 47 = 1 (stop)
- Each bit is held exactly CLK_DIV cycles. A divider counter runs 0..CLK_DIV-1 and bit_cnt increments on divider wrap. Frame length is exactly 48*CLK_DIV cycles.
- CRC7: generator x^7+x^3+1, register initialised to 0 at handshake, advanced once per bit over bits 0..39, frozen during 40..46. Bits 40..46 shift it out MSB first. With CRC_EN=0, the latched cmd_crc is sent instead.
- SEND→GAP at the end of bit 47's last cycle. In the next cycle: done=1 (single cycle), cmd_oe=0, cmd_out=1, bit_cnt=0.
- GAP lasts GAP_BITS*CLK_DIV cycles, starting with the done cycle; cmd_ready=0 throughout. GAP→IDLE afterwards.
- GAP_BITS=0: SEND→IDLE directly. cmd_ready=1 in the done cycle, so a handshake there starts the next frame in the following cycle. Minimum spacing between frames is one non-driven cycle.
- cmd_valid while not ready is ignored; no queuing.
- The block does not require cmd_valid to be held. A dropped request before ready is simply not sent.
- busy = (state != IDLE).
- rst mid-frame or mid-gap: the next edge returns all outputs to reset values. The frame is abandoned and no done is generated.

Test Plan:
- CLK_DIV=1, GAP_BITS=8: send CMD0 with arg 0x00000000 → serial bytes 0x40 00 00 00 00 0x95; cmd_oe high for exactly 48 cycles; done pulse at cycle 49 after handshake; cmd_ready returns 8 cycles after done rises.
- CRC golden values, CRC_EN=1:
  - CMD8 with arg 0x000001AA → last byte 0x87
  - CMD17 with arg 0 → last byte 0x55
  - CMD2 with arg 0 → last byte 0x4D
- CLK_DIV=4: CMD3 with arg 0x00010000 → each bit is stable for 4 cycles; frame is 192 cycles; bit_cnt steps every 4 cycles 0..47 then returns to 0.
- CRC_EN=0 with cmd_crc=0x55 and arbitrary index/arg → bits 40..46 are 1010101; cmd_index and cmd_arg changed after the handshake do not alter the frame.
- GAP_BITS=0: back-to-back handshakes → second frame's start bit occurs exactly one cycle after the first frame's stop bit ends. cmd_valid asserted during SEND is not accepted.
- rst asserted at bit 20 of a frame → next cycle cmd_oe=0, cmd_out=1, bit_cnt=0, no done pulse. cmd_ready=1 the cycle after rst drops, and a fresh CMD0 then produces a correct 0x95 trailer.

Source files
------------

// File: rtl/mmc_cmd_serializer_if.sv
// rtl/mmc_cmd_serializer_if.sv - command request handshake between the command FSM and the CMD serializer
interface mmc_cmd_serializer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;

    modport master (
        output cmd_valid,
        output cmd_index,
        output cmd_arg,
        output cmd_crc,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_index,
        input  cmd_arg,
        input  cmd_crc,
        output cmd_ready
    );
endinterface

// File: rtl/mmc_cmd_serializer.sv
// rtl/mmc_cmd_serializer.sv - MMC/SD 48-bit command frame transmitter with serial CRC7 and idle gap
module mmc_cmd_serializer #(
    parameter int CLK_DIV  = 2,
    parameter int GAP_BITS = 8,
    parameter bit CRC_EN   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    mmc_cmd_serializer_if.slave        cmd,
    output logic                       cmd_out,
    output logic                       cmd_oe,
    output logic                       busy,
    output logic [5:0]                 bit_cnt,
    output logic                       done
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam int          GAP_LEN  = GAP_BITS * CLK_DIV;
    localparam logic [31:0] GAP_LAST = 32'(GAP_LEN - 1);

    state_t      state, state_n;
    logic [7:0]  div_cnt, div_n;
    logic [5:0]  bit_n, nxt_bit, tr_idx;
    logic [31:0] gap_cnt, gap_n;
    logic [39:0] sh, sh_n;
    logic [6:0]  crc, crc_n, crc_ext, crc_ext_n;
    logic [6:0]  crc_adv, trailer;
    logic        fb;
    logic        ready_q, ready_n;
    logic        out_n, oe_n, busy_n, done_n;

    assign cmd.cmd_ready = ready_q;

    // Next state, next datapath and next registered outputs
    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        bit_n     = bit_cnt;
        gap_n     = gap_cnt;
        sh_n      = sh;
        crc_n     = crc;
        crc_ext_n = crc_ext;
        ready_n   = 1'b0;
        out_n     = 1'b1;
        oe_n      = 1'b0;
        done_n    = 1'b0;
        // Serial CRC7 step (x^7 + x^3 + 1) on the bit currently on the line
        fb        = sh[39] ^ crc[6];
        crc_adv   = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
        nxt_bit   = bit_cnt + 6'd1;
        tr_idx    = 6'd46 - nxt_bit;
        trailer   = '0;

        case (state)
            S_IDLE: begin
                ready_n = 1'b1;
                if (cmd.cmd_valid && ready_q) begin
                    state_n   = S_SEND;
                    ready_n   = 1'b0;
                    sh_n      = {2'b01, cmd.cmd_index, cmd.cmd_arg};
                    crc_n     = '0;
                    crc_ext_n = cmd.cmd_crc;
                    div_n     = '0;
                    bit_n     = '0;
                    out_n     = 1'b0;
                    oe_n      = 1'b1;
                end
            end
            S_SEND: begin
                oe_n  = 1'b1;
                out_n = cmd_out;
                if (div_cnt != DIV_LAST) begin
                    div_n = div_cnt + 8'd1;
                end else begin
                    div_n = '0;
                    if (bit_cnt == 6'd47) begin
                        bit_n  = '0;
                        oe_n   = 1'b0;
                        out_n  = 1'b1;
                        done_n = 1'b1;
                        gap_n  = '0;
                        if (GAP_BITS == 0) begin
                            state_n = S_IDLE;
                            ready_n = 1'b1;
                        end else begin
                            state_n = S_GAP;
                        end
                    end else begin
                        bit_n = nxt_bit;
                        // CRC covers bits 0..39 only and is frozen while it is sent
                        if (bit_cnt < 6'd40) begin
                            crc_n = crc_adv;
                            sh_n  = {sh[38:0], 1'b0};
                        end
                        trailer = CRC_EN ? crc_n : crc_ext;
                        if (nxt_bit < 6'd40) begin
                            out_n = sh_n[39];
                        end else if (nxt_bit < 6'd47) begin
                            out_n = trailer[tr_idx[2:0]];
                        end else begin
                            out_n = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = S_IDLE;
                    ready_n = 1'b1;
                end else begin
                    gap_n = gap_cnt + 32'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sh      <= '0;
            crc     <= '0;
            crc_ext <= '0;
            ready_q <= 1'b0;
            cmd_out <= 1'b1;
            cmd_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            gap_cnt <= gap_n;
            sh      <= sh_n;
            crc     <= crc_n;
            crc_ext <= crc_ext_n;
            ready_q <= ready_n;
            cmd_out <= out_n;
            cmd_oe  <= oe_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end
endmodule
